// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
// Mode encoding matches the external 2-bit mode port.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_t;

endpackage

// File: rtl/shift_frame_counter.sv
// Counts shifts within a frame of WIDTH bits.
// Emits a registered one-cycle pulse on the wrapping shift.
module shift_frame_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_strobe,
  input  logic             clear,
  output logic [CNT_W-1:0] bit_count,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (shift_strobe) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bit_count  = cnt_q;
  assign frame_done = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// Bidirectional WIDTH-bit shift register with parallel load,
// clock enable and a frame counter for serialiser use.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic [CNT_W-1:0] bit_count,
  output logic             frame_done
);

  shift_mode_t      mode_e;
  logic [WIDTH-1:0] q_q, q_d;
  logic             is_shift;
  logic             is_load;

  assign mode_e   = shift_mode_t'(mode);
  assign is_shift = en & ((mode_e == MODE_SHR) | (mode_e == MODE_SHL));
  assign is_load  = en & (mode_e == MODE_LOAD);

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case (mode_e)
        MODE_HOLD: q_d = q_q;
        MODE_SHR:  q_d = {serial_in_r, q_q[WIDTH-1:1]};
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], serial_in_l};
        MODE_LOAD: q_d = par_in;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  shift_frame_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .shift_strobe (is_shift),
    .clear        (is_load),
    .bit_count    (bit_count),
    .frame_done   (frame_done)
  );

  assign par_out      = q_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench: directed vector table plus random
// stimulus against a behavioural model, WIDTH=4.
module tb_universal_shift_register;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          sir;
  logic          sil;
  logic [W-1:0]  par_in;
  logic [W-1:0]  par_out;
  logic          sor;
  logic          sol;
  logic [CW-1:0] bit_count;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .serial_in_r  (sir),
    .serial_in_l  (sil),
    .par_in       (par_in),
    .par_out      (par_out),
    .serial_out_r (sor),
    .serial_out_l (sol),
    .bit_count    (bit_count),
    .frame_done   (frame_done)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sir;
    logic       sil;
    logic [3:0] par;
    logic [3:0] ep;
    int         ec;
    logic       efd;
  } vec_t;

  vec_t tbl[$];

  // behavioural model: integer register and shifts-in-frame count
  int m_q = 0;
  int m_n = 0;
  int m_fd = 0;

  function automatic vec_t mk(input logic r, input logic e,
                              input logic [1:0] m, input logic i_r,
                              input logic i_l, input logic [3:0] p,
                              input logic [3:0] ep, input int ec,
                              input logic efd);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sir = i_r; v.sil = i_l;
    v.par = p; v.ep = ep; v.ec = ec; v.efd = efd;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e,
                            input logic [1:0] m, input logic i_r,
                            input logic i_l, input logic [3:0] p);
    m_fd = 0;
    if (r) begin
      m_q = 0; m_n = 0;
    end else if (e) begin
      if (m == 2'd1 || m == 2'd2) begin
        if (m == 2'd1) m_q = (int'(i_r) * (1 << (W - 1))) + (m_q / 2);
        else           m_q = (m_q * 2 + int'(i_l)) % (1 << W);
        m_n++;
        if (m_n == W) begin
          m_n = 0; m_fd = 1;
        end
      end else if (m == 2'd3) begin
        m_q = int'(p); m_n = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic [1:0] m, input logic i_r,
                       input logic i_l, input logic [3:0] p);
    @(negedge clk);
    rst = r; en = e; mode = m; sir = i_r; sil = i_l; par_in = p;
    @(posedge clk);
    #1;
    model_step(r, e, m, i_r, i_l, p);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00;
    sir = 1'b0; sil = 1'b0; par_in = '0;

    // reset with load requested
    tbl.push_back(mk(1,1,3,0,0,4'hF, 4'b0000,0,0));
    // shift right 1,0,1,1
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1000,1,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0, 4'b0100,2,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1010,3,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1101,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'h0, 4'b1101,0,0));
    // load 1001 then shift left with zeros
    tbl.push_back(mk(0,1,3,0,0,4'h9, 4'b1001,0,0));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b0010,1,0));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b0100,2,0));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b1000,3,0));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b0000,0,1));
    // enable gating
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1000,1,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1100,2,0));
    tbl.push_back(mk(0,0,1,1,1,4'h0, 4'b1100,2,0));
    tbl.push_back(mk(0,0,2,1,1,4'h0, 4'b1100,2,0));
    tbl.push_back(mk(0,0,3,1,1,4'h5, 4'b1100,2,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0, 4'b0110,3,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0, 4'b0011,0,1));
    // abort by load
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1001,1,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1100,2,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1110,3,0));
    tbl.push_back(mk(0,1,3,0,0,4'hA, 4'b1010,0,0));
    // abort by reset
    tbl.push_back(mk(0,1,1,0,0,4'h0, 4'b0101,1,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0, 4'b0010,2,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0, 4'b0001,3,0));
    tbl.push_back(mk(1,1,1,0,0,4'h0, 4'b0000,0,0));
    tbl.push_back(mk(0,1,1,0,0,4'h0, 4'b0000,1,0));
    // continuous: 6 right then 6 left
    tbl.push_back(mk(1,0,0,0,0,4'h0, 4'b0000,0,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1000,1,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1100,2,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1110,3,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1111,0,1));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1111,1,0));
    tbl.push_back(mk(0,1,1,1,0,4'h0, 4'b1111,2,0));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b1110,3,0));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b1100,0,1));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b1000,1,0));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b0000,2,0));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b0000,3,0));
    tbl.push_back(mk(0,1,2,0,0,4'h0, 4'b0000,0,1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].mode,
            tbl[i].sir, tbl[i].sil, tbl[i].par);
      check($sformatf("vec%0d par_out", i), int'(par_out), int'(tbl[i].ep));
      check($sformatf("vec%0d bit_count", i), int'(bit_count), tbl[i].ec);
      check($sformatf("vec%0d frame_done", i), int'(frame_done), int'(tbl[i].efd));
      check($sformatf("vec%0d serial_out_r", i), int'(sor), int'(tbl[i].ep[0]));
      check($sformatf("vec%0d serial_out_l", i), int'(sol), int'(tbl[i].ep[3]));
    end

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      logic       r, e, a, b;
      logic [1:0] m;
      logic [3:0] p;
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 9) < 8);
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) m = 2'd1;
      a = 1'($urandom);
      b = 1'($urandom);
      p = 4'($urandom);
      drive(r, e, m, a, b, p);
      check($sformatf("rnd%0d par_out", i), int'(par_out), m_q);
      check($sformatf("rnd%0d bit_count", i), int'(bit_count), m_n);
      check($sformatf("rnd%0d frame_done", i), int'(frame_done), m_fd);
      check($sformatf("rnd%0d serial_out_r", i), int'(sor), m_q % 2);
      check($sformatf("rnd%0d serial_out_l", i), int'(sol), m_q / (1 << (W - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
